// File: rtl/riscv_types.sv
// Shared RV32A types: the amo_t fn5 encoding plus the state and reservation
// types used by the atomic-memory-operation engine.
package riscv_types;

    localparam int AMO_XLEN      = 32;
    localparam int AMO_GRANULE_W = 2;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        WRITE,
        RESPOND
    } amo_state_t;

    // Sized by the package constants; the unit's XLEN/GRANULE_W must match them.
    typedef struct packed {
        logic                                valid;
        logic [AMO_XLEN-AMO_GRANULE_W-1:0]   addr;
    } reservation_t;

    function automatic logic is_amo_op(input logic [4:0] fn5);
        case (fn5)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_reservation_unit_if.sv
// Request, memory-port, snoop and response signals of the AMO engine.
// The engine uses the slave view; the load/store side and memory use master.
interface amo_reservation_unit_if #(
    parameter int XLEN   = 32,
    parameter int HART_W = 1,
    parameter int ID_W   = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic [HART_W-1:0] req_hart;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_rs2;
    logic [ID_W-1:0]   req_id;

    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_rdata_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [XLEN-1:0]   mem_wdata;

    logic              snoop_valid;
    logic [XLEN-1:0]   snoop_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [ID_W-1:0]   rsp_id;

    modport slave (
        input  req_valid, req_op, req_hart, req_addr, req_rs2, req_id,
        input  mem_rd_ready, mem_rdata_valid, mem_rdata, mem_wr_ready,
        input  snoop_valid, snoop_addr, rsp_ready,
        output req_ready, mem_rd_valid, mem_addr, mem_wr_valid, mem_wdata,
        output rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_op, req_hart, req_addr, req_rs2, req_id,
        output mem_rd_ready, mem_rdata_valid, mem_rdata, mem_wr_ready,
        output snoop_valid, snoop_addr, rsp_ready,
        input  req_ready, mem_rd_valid, mem_addr, mem_wr_valid, mem_wdata,
        input  rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/amo_alu.sv
// Combinational modify step of an AMO read-modify-write. LR/SC and unknown
// codes pass the old value through; ties in min/max keep the old value.
module amo_alu
    import riscv_types::*;
#(
    parameter int XLEN = AMO_XLEN
) (
    input  amo_t            op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result
);

    logic rs2_lt_s;
    logic rs2_gt_s;
    logic rs2_lt_u;
    logic rs2_gt_u;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rs2_lt_s = $signed(rs2) < $signed(old);
        rs2_gt_s = $signed(rs2) > $signed(old);
        rs2_lt_u = rs2 < old;
        rs2_gt_u = rs2 > old;
        result   = old;
        case (op)
            AMO_SWAP: result = rs2;
            AMO_ADD:  result = old + rs2;
            AMO_XOR:  result = old ^ rs2;
            AMO_AND:  result = old & rs2;
            AMO_OR:   result = old | rs2;
            AMO_MIN:  result = rs2_lt_s ? rs2 : old;
            AMO_MAX:  result = rs2_gt_s ? rs2 : old;
            AMO_MINU: result = rs2_lt_u ? rs2 : old;
            AMO_MAXU: result = rs2_gt_u ? rs2 : old;
            default:  result = old;
        endcase
    end

endmodule

// File: rtl/amo_reservation_unit.sv
// RV32A atomic engine: one read-modify-write in flight, one LR/SC reservation
// per hart, reservations invalidated by external-store snoops and own writes.
module amo_reservation_unit
    import riscv_types::*;
#(
    parameter int XLEN      = AMO_XLEN,
    parameter int NUM_HARTS = 1,
    parameter int GRANULE_W = AMO_GRANULE_W,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    amo_reservation_unit_if.slave bus
);

    localparam int HART_W  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int GRAN_AW = XLEN - GRANULE_W;

    function automatic logic [GRAN_AW-1:0] granule_of(input logic [XLEN-1:0] a);
        return a[XLEN-1:GRANULE_W];
    endfunction

    amo_state_t        state_q, state_d;
    amo_t              op_q;
    logic [HART_W-1:0] hart_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   rs2_q;
    logic [ID_W-1:0]   id_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic [XLEN-1:0]   alu_result;

    reservation_t      res_q [NUM_HARTS];
    reservation_t      res_d [NUM_HARTS];

    logic              accept, sc_accept, sc_pass, lr_set, old_load, wr_done, rsp_load;
    logic [XLEN-1:0]   rsp_next;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .op     (op_q),
        .old    (old_q),
        .rs2    (rs2_q),
        .result (alu_result)
    );

    // SC success is judged against the reservation as it stands in the accept cycle.
    always_comb begin
        sc_pass = 1'b0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (h == int'(bus.req_hart) && res_q[h].valid &&
                res_q[h].addr == granule_of(bus.req_addr))
                sc_pass = 1'b1;
        end
        if (bus.snoop_valid && granule_of(bus.snoop_addr) == granule_of(bus.req_addr))
            sc_pass = 1'b0;
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready    = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_wr_valid = 1'b0;
        bus.rsp_valid    = 1'b0;
        accept           = 1'b0;
        sc_accept        = 1'b0;
        lr_set           = 1'b0;
        old_load         = 1'b0;
        wr_done          = 1'b0;
        rsp_load         = 1'b0;
        rsp_next         = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (!is_amo_op(bus.req_op)) begin
                        state_d  = RESPOND;
                        rsp_load = 1'b1;
                    end else if (bus.req_op == AMO_SC) begin
                        sc_accept = 1'b1;
                        if (sc_pass) begin
                            state_d = WRITE;
                        end else begin
                            state_d  = RESPOND;
                            rsp_load = 1'b1;
                            rsp_next = XLEN'(1);
                        end
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                bus.mem_rd_valid = 1'b1;
                if (bus.mem_rd_ready) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.mem_rdata_valid) begin
                    old_load = 1'b1;
                    if (op_q == AMO_LR) begin
                        lr_set   = 1'b1;
                        rsp_load = 1'b1;
                        rsp_next = bus.mem_rdata;
                        state_d  = RESPOND;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                bus.mem_wr_valid = 1'b1;
                if (bus.mem_wr_ready) begin
                    wr_done  = 1'b1;
                    rsp_load = 1'b1;
                    rsp_next = (op_q == AMO_SC) ? '0 : old_q;
                    state_d  = RESPOND;
                end
            end
            RESPOND: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Later rules override earlier ones; the snoop is applied last so it beats an LR set.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            res_d[h] = res_q[h];
            if (lr_set && h == int'(hart_q)) begin
                res_d[h].valid = 1'b1;
                res_d[h].addr  = granule_of(addr_q);
            end
            if (sc_accept && h == int'(bus.req_hart))
                res_d[h].valid = 1'b0;
            if (wr_done && h != int'(hart_q) && res_q[h].addr == granule_of(addr_q))
                res_d[h].valid = 1'b0;
            if (bus.snoop_valid && res_d[h].addr == granule_of(bus.snoop_addr))
                res_d[h].valid = 1'b0;
        end
    end

    // NOTE: control state and the small reservation file are reset; the datapath registers below are not, because they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int h = 0; h < NUM_HARTS; h++) res_q[h] <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= amo_t'(bus.req_op);
            hart_q <= bus.req_hart;
            addr_q <= bus.req_addr;
            rs2_q  <= bus.req_rs2;
            id_q   <= bus.req_id;
        end
        if (old_load) old_q      <= bus.mem_rdata;
        if (rsp_load) rsp_data_q <= rsp_next;
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = (op_q == AMO_SC) ? rs2_q : alu_result;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_amo_reservation_unit.sv
// Scoreboard bench for amo_reservation_unit: the driver queues expected
// responses and writes; memory and response monitors pop and compare.
module tb_amo_reservation_unit;
    import riscv_types::*;

    localparam int XLEN      = 32;
    localparam int NUM_HARTS = 2;
    localparam int HART_W    = 1;
    localparam int ID_W      = 2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        int          lat;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    amo_reservation_unit_if #(.XLEN(XLEN), .HART_W(HART_W), .ID_W(ID_W)) bus ();

    amo_reservation_unit #(
        .XLEN(XLEN), .NUM_HARTS(NUM_HARTS), .GRANULE_W(2), .ID_W(ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rsp_exp_t    rsp_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          rd_stall = 0;
    int          wr_stall = 0;
    int          rsp_stall = 0;
    int          rd_pend = 0;
    int          rsp_lat = 0;
    bit          rsp_seen = 1'b0;
    logic [31:0] rd_addr;
    logic [31:0] cur_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory: read data returns after one dead cycle following the read handshake.
    initial begin : mem_model
        bus.mem_rd_ready    = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = '0;
        bus.mem_wr_ready    = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_rdata_valid = 1'b0;
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata       = mem_read(rd_addr);
                end
            end
            bus.mem_rd_ready = 1'b0;
            if (bus.mem_rd_valid) begin
                check("rd_addr", bus.mem_addr, cur_addr);
                check("rd_req_ready_low", 32'(bus.req_ready), 32'd0);
                if (rd_stall > 0) begin
                    rd_stall--;
                end else begin
                    bus.mem_rd_ready = 1'b1;
                    rd_pend = 2;
                    rd_addr = bus.mem_addr;
                end
            end
            bus.mem_wr_ready = 1'b0;
            if (bus.mem_wr_valid) begin
                if (wr_q.size() == 0) begin
                    check("no_write_expected", 32'(bus.mem_wr_valid), 32'd0);
                    bus.mem_wr_ready = 1'b1;
                end else begin
                    check("wr_addr", bus.mem_addr, wr_q[0].addr);
                    check("wr_data", bus.mem_wdata, wr_q[0].data);
                    check("wr_req_ready_low", 32'(bus.req_ready), 32'd0);
                    if (wr_stall > 0) begin
                        wr_stall--;
                    end else begin
                        bus.mem_wr_ready = 1'b1;
                        mem[bus.mem_addr] = bus.mem_wdata;
                        void'(wr_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : rsp_monitor
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (!bus.rsp_valid) begin
                rsp_seen = 1'b0;
            end else if (rsp_q.size() == 0) begin
                check("no_rsp_expected", 32'(bus.rsp_valid), 32'd0);
                bus.rsp_ready = 1'b1;
            end else begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    rsp_lat  = cyc - accept_cyc + 1;
                end
                check("rsp_data", bus.rsp_data, rsp_q[0].data);
                check("rsp_id", 32'(bus.rsp_id), 32'(rsp_q[0].id));
                if (rsp_stall > 0) begin
                    check("rsp_req_ready_low", 32'(bus.req_ready), 32'd0);
                    rsp_stall--;
                end else begin
                    bus.rsp_ready = 1'b1;
                    if (rsp_q[0].lat > 0)
                        check("rsp_latency", 32'(rsp_lat), 32'(rsp_q[0].lat));
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    task automatic start_req(input logic [4:0] op, input logic hart, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [1:0] id,
                             input logic [31:0] exp_rsp, input int exp_lat,
                             input bit exp_wr, input logic [31:0] exp_wdata,
                             input bit snoop_now, input logic [31:0] snoop_a);
        int guard = 0;
        @(negedge clk);
        cur_addr = addr;
        rsp_q.push_back('{data: exp_rsp, id: id, lat: exp_lat});
        if (exp_wr) wr_q.push_back('{addr: addr, data: exp_wdata});
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_hart  = hart;
        bus.req_addr  = addr;
        bus.req_rs2   = rs2;
        bus.req_id    = id;
        if (snoop_now) begin
            bus.snoop_valid = 1'b1;
            bus.snoop_addr  = snoop_a;
        end
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.snoop_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            fail_now("completion_timeout");
            rsp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic hart, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [1:0] id,
                         input logic [31:0] exp_rsp, input int exp_lat,
                         input bit exp_wr, input logic [31:0] exp_wdata);
        start_req(op, hart, addr, rs2, id, exp_rsp, exp_lat, exp_wr, exp_wdata, 1'b0, 32'h0);
        wait_done();
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge clk);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = a;
        @(negedge clk);
        bus.snoop_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int guard;
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_hart    = '0;
        bus.req_addr    = '0;
        bus.req_rs2     = '0;
        bus.req_id      = '0;
        bus.snoop_valid = 1'b0;
        bus.snoop_addr  = '0;
        mem[32'h100] = 32'h5;
        mem[32'h180] = 32'hFFFF_FFFF;
        mem[32'h184] = 32'hFFFF_FFFF;
        mem[32'h188] = 32'hFFFF_FFFF;
        mem[32'h190] = 32'hF0F0_00FF;
        mem[32'h200] = 32'h77;
        mem[32'h204] = 32'h10;
        mem[32'h300] = 32'h33;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
        check("reset_wr_valid", 32'(bus.mem_wr_valid), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;

        // LR/SC pair on one hart, then SC again with the reservation consumed.
        issue(AMO_LR, 1'b0, 32'h100, 32'h0, 2'd1, 32'h5, 4, 1'b0, 32'h0);
        issue(AMO_SC, 1'b0, 32'h100, 32'h9, 2'd2, 32'h0, 0, 1'b1, 32'h9);
        issue(AMO_SC, 1'b0, 32'h100, 32'hA, 2'd3, 32'h1, 1, 1'b0, 32'h0);

        // Snoop into the same word between LR and SC.
        issue(AMO_LR, 1'b0, 32'h100, 32'h0, 2'd0, 32'h9, 4, 1'b0, 32'h0);
        snoop(32'h102);
        issue(AMO_SC, 1'b0, 32'h100, 32'h1, 2'd1, 32'h1, 1, 1'b0, 32'h0);

        // Snoop in the SC accept cycle.
        issue(AMO_LR, 1'b0, 32'h100, 32'h0, 2'd2, 32'h9, 4, 1'b0, 32'h0);
        start_req(AMO_SC, 1'b0, 32'h100, 32'h1, 2'd3, 32'h1, 1, 1'b0, 32'h0, 1'b1, 32'h100);
        wait_done();

        // Snoop to a different word leaves the reservation intact.
        issue(AMO_LR, 1'b0, 32'h100, 32'h0, 2'd0, 32'h9, 4, 1'b0, 32'h0);
        snoop(32'h104);
        issue(AMO_SC, 1'b0, 32'h100, 32'h11, 2'd1, 32'h0, 0, 1'b1, 32'h11);

        // ALU operations.
        issue(AMO_MIN,  1'b0, 32'h180, 32'h1, 2'd2, 32'hFFFF_FFFF, 5, 1'b1, 32'hFFFF_FFFF);
        issue(AMO_MINU, 1'b0, 32'h184, 32'h1, 2'd3, 32'hFFFF_FFFF, 5, 1'b1, 32'h1);
        issue(AMO_ADD,  1'b0, 32'h188, 32'h2, 2'd0, 32'hFFFF_FFFF, 5, 1'b1, 32'h1);
        issue(AMO_MAX,  1'b0, 32'h184, 32'h8000_0000, 2'd1, 32'h1, 5, 1'b1, 32'h1);
        issue(AMO_MAXU, 1'b0, 32'h184, 32'h8000_0000, 2'd2, 32'h1, 5, 1'b1, 32'h8000_0000);
        issue(AMO_XOR,  1'b0, 32'h190, 32'h0FF0_0F0F, 2'd3, 32'hF0F0_00FF, 5, 1'b1, 32'hFF00_0FF0);
        issue(AMO_AND,  1'b0, 32'h190, 32'hF000_FFFF, 2'd0, 32'hFF00_0FF0, 5, 1'b1, 32'hF000_0FF0);
        issue(AMO_OR,   1'b0, 32'h190, 32'h0000_000F, 2'd1, 32'hF000_0FF0, 5, 1'b1, 32'hF000_0FFF);
        issue(AMO_MIN,  1'b0, 32'h190, 32'hF000_0FFF, 2'd2, 32'hF000_0FFF, 5, 1'b1, 32'hF000_0FFF);
        issue(5'b00101, 1'b0, 32'h190, 32'h1234, 2'd3, 32'h0, 1, 1'b0, 32'h0);

        // Two harts: a swap by hart 1 kills hart 0's reservation but not its own.
        issue(AMO_LR,   1'b0, 32'h200, 32'h0,  2'd0, 32'h77, 4, 1'b0, 32'h0);
        issue(AMO_LR,   1'b1, 32'h200, 32'h0,  2'd1, 32'h77, 4, 1'b0, 32'h0);
        issue(AMO_SWAP, 1'b1, 32'h200, 32'hAB, 2'd2, 32'h77, 5, 1'b1, 32'hAB);
        issue(AMO_SC,   1'b0, 32'h200, 32'h5,  2'd3, 32'h1,  1, 1'b0, 32'h0);
        issue(AMO_SC,   1'b1, 32'h200, 32'hCD, 2'd0, 32'h0,  0, 1'b1, 32'hCD);

        // Back-pressure on every channel.
        rd_stall  = 3;
        wr_stall  = 3;
        rsp_stall = 3;
        issue(AMO_ADD, 1'b0, 32'h204, 32'h5, 2'd3, 32'h10, 0, 1'b1, 32'h15);

        // Reset while the write is pending.
        issue(AMO_LR, 1'b0, 32'h300, 32'h0, 2'd1, 32'h33, 4, 1'b0, 32'h0);
        wr_stall = 50;
        start_req(AMO_SWAP, 1'b1, 32'h308, 32'h99, 2'd2, 32'h0, 0, 1'b1, 32'h99, 1'b0, 32'h0);
        guard = 0;
        while (!bus.mem_wr_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("wr_valid_before_reset", 32'(bus.mem_wr_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rsp_q.delete();
        wr_q.delete();
        wr_stall = 0;
        @(negedge clk);
        check("abort_wr_valid", 32'(bus.mem_wr_valid), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_mem_unchanged", mem_read(32'h308), 32'h0);
        issue(AMO_SC, 1'b0, 32'h300, 32'h44, 2'd3, 32'h1, 1, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amo_reservation_unit.md
Name: amo_reservation_unit

Overview:
Parametrised atomic-memory-operation engine for the RV32A path, between the load/store unit and the data memory port. Executes all amo_t operations (LR, SC, SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU) as a read-modify-write sequence. Tracks one LR/SC reservation per hart across NUM_HARTS harts, with snoop-based invalidation from external stores.

Parameters:
XLEN, 32, data/address width
NUM_HARTS, 1, number of reservation registers, one per hart; HART_W = max(1, $clog2(NUM_HARTS))
GRANULE_W, 2, low address bits ignored in reservation compare (2 means word granule)
ID_W, 2, request tag width, returned unchanged with the response

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  AMO request valid
req_ready  out  1  unit can accept a request
req_op  in  5  amo_t fn5 code
req_hart  in  HART_W  issuing hart
req_addr  in  XLEN  word-aligned address
req_rs2  in  XLEN  rs2 operand
req_id  in  ID_W  request tag
mem_rd_valid  out  1  read request
mem_rd_ready  in  1  memory accepts read
mem_addr  out  XLEN  address for read and write
mem_rdata_valid  in  1  read data return
mem_rdata  in  XLEN  read data
mem_wr_valid  out  1  write request
mem_wr_ready  in  1  memory accepts write
mem_wdata  out  XLEN  write data
snoop_valid  in  1  external store committed
snoop_addr  in  XLEN  external store address
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  XLEN  rd value
rsp_id  out  ID_W  tag of completed request

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk, rst. On reset: FSM goes to IDLE; req_ready=1; mem_rd_valid, mem_wr_valid, rsp_valid=0; all reservations invalid.
- Reset mid-operation abandons the operation. No write and no response are issued afterwards.
- FSM states: IDLE, READ, WAIT_DATA, WRITE, RESPOND. Only one operation is in flight.
- IDLE: req_ready=1. A req_valid&req_ready handshake latches op/hart/addr/rs2/id. The next state depends on the op:
  - SC: go to WRITE if the reservation passes, otherwise RESPOND with rsp_data=1. The hart's reservation is cleared in either case.
  - Unknown fn5: go to RESPOND with rsp_data=0, no memory traffic.
  - All other ops: go to READ.
- SC pass condition: res_valid[hart] and res_addr[hart] == addr[XLEN-1:GRANULE_W], evaluated in the accept cycle. A snoop matching in that same cycle makes the SC fail.
- READ: mem_rd_valid=1 and held until mem_rd_ready. Then go to WAIT_DATA.
- WAIT_DATA: wait for mem_rdata_valid and latch old value.
  - LR: set res[hart]={1, addr granule} unless a snoop matches that cycle. Then go to RESPOND with rsp_data=old.
  - Other ops: go to WRITE.
- WRITE: mem_wr_valid=1, mem_wdata=amo_alu(op, old, rs2). For SC, mem_wdata=rs2. Held until mem_wr_ready. On handshake:
  - Clear reservations of all other harts whose granule matches.
  - Go to RESPOND with rsp_data=old (0 for SC).
- RESPOND: rsp_valid=1, held stable until rsp_ready. Then return to IDLE. req_ready is not asserted in the same cycle.
- ALU rules:
  - ADD wraps modulo 2^XLEN.
  - MIN/MAX compare signed XLEN; MINU/MAXU compare unsigned.
  - Equal operands select old.
- Snoop: each cycle, clears every hart's reservation whose granule matches snoop_addr. Snoop has priority over a same-cycle LR reservation set.
- Minimum latency, accept to rsp_valid with zero-wait memory (rdata one cycle after read handshake):
  - AMO: 5 cycles.
  - LR: 4 cycles.
  - Failed SC: 1 cycle.
- A new LR from a hart overwrites that hart's previous reservation.

Decomposition:
- riscv_types package (alongside the existing amo_t): amo_state_t enum; reservation_t struct {valid, addr[XLEN-GRANULE_W-1:0]}.
- One sub-module, amo_alu: combinational; inputs op, old, rs2; output new value.

Test Plan:
- LR hart0 @0x100 (mem=0x5) then SC hart0 @0x100 rs2=0x9 -> LR rsp 0x5; SC rsp 0; write 0x9 @0x100; reservation cleared.
- LR @0x100, snoop_addr=0x102, then SC -> SC rsp 1; no mem_wr_valid. Repeat with snoop in the SC accept cycle -> SC fails.
- AMOMIN mem=0xFFFFFFFF rs2=0x1 -> write 0xFFFFFFFF, rsp 0xFFFFFFFF. AMOMINU with the same values -> write 0x1. AMOADD 0xFFFFFFFF+0x2 -> write 0x1.
- NUM_HARTS=2: both harts LR @0x200; hart1 AMOSWAP @0x200 -> hart0 SC fails with rsp 1; hart1 reservation unchanged by its own swap.
- Stall mem_rd_ready, mem_wr_ready and rsp_ready 3 cycles each -> valids and data held stable; req_ready=0 throughout; single response with correct id.
- Assert rst during WRITE -> mem_wr_valid=0 the next cycle; no rsp; req_ready=1; prior reservations invalid.
